// File: rtl/core_csr_file.sv
// Machine-mode CSR file for the LETC core: trap/MRET state, mtvec/mscratch, and the
// 64-bit cycle and instret counters, read combinationally through stage 2's CSR port.
module core_csr_file #(
    parameter logic [31:0] MHARTID    = 32'h0,
    parameter logic [31:0] MISA_VALUE = 32'h4000_1100
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [11:0] csr_sel,
    input  logic [31:0] csr_wd,
    input  logic        csr_we,
    output logic [31:0] csr_data_out,
    output logic        csr_illegal,

    input  logic        instret_inc,

    input  logic        trap_en,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_en,

    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mie_out
);

    localparam logic [11:0] AddrMstatus   = 12'h300;
    localparam logic [11:0] AddrMisa      = 12'h301;
    localparam logic [11:0] AddrMtvec     = 12'h305;
    localparam logic [11:0] AddrMscratch  = 12'h340;
    localparam logic [11:0] AddrMepc      = 12'h341;
    localparam logic [11:0] AddrMcause    = 12'h342;
    localparam logic [11:0] AddrMtval     = 12'h343;
    localparam logic [11:0] AddrMcycle    = 12'hB00;
    localparam logic [11:0] AddrMinstret  = 12'hB02;
    localparam logic [11:0] AddrMcycleh   = 12'hB80;
    localparam logic [11:0] AddrMinstreth = 12'hB82;
    localparam logic [11:0] AddrCycle     = 12'hC00;
    localparam logic [11:0] AddrInstret   = 12'hC02;
    localparam logic [11:0] AddrCycleh    = 12'hC80;
    localparam logic [11:0] AddrInstreth  = 12'hC82;
    localparam logic [11:0] AddrMhartid   = 12'hF14;

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic        csr_known;
    logic        csr_read_only;
    logic [31:0] csr_rdata;
    logic        wr_en;

    // mepc is word aligned, so the low trap_pc bits are dropped by design.
    logic        unused_trap_pc_lsbs;
    assign unused_trap_pc_lsbs = ^trap_pc[1:0];

    // ---------------------------------------------------------------
    // Read decode
    // ---------------------------------------------------------------
    always_comb begin
        csr_known = 1'b1;
        csr_rdata = 32'h0;
        case (csr_sel)
            AddrMstatus:   csr_rdata = {19'h0, 2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};
            AddrMisa:      csr_rdata = MISA_VALUE;
            AddrMtvec:     csr_rdata = mtvec_q;
            AddrMscratch:  csr_rdata = mscratch_q;
            AddrMepc:      csr_rdata = mepc_q;
            AddrMcause:    csr_rdata = mcause_q;
            AddrMtval:     csr_rdata = mtval_q;
            AddrMcycle,
            AddrCycle:     csr_rdata = mcycle_q[31:0];
            AddrMcycleh,
            AddrCycleh:    csr_rdata = mcycle_q[63:32];
            AddrMinstret,
            AddrInstret:   csr_rdata = minstret_q[31:0];
            AddrMinstreth,
            AddrInstreth:  csr_rdata = minstret_q[63:32];
            AddrMhartid:   csr_rdata = MHARTID;
            default:       csr_known = 1'b0;
        endcase
    end

    assign csr_read_only = (csr_sel[11:10] == 2'b11);
    assign csr_illegal   = !csr_known || (csr_we && csr_read_only);
    assign csr_data_out  = csr_illegal ? 32'h0 : csr_rdata;
    assign wr_en         = csr_we && !csr_illegal;

    // ---------------------------------------------------------------
    // Next state
    // ---------------------------------------------------------------
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;

        // A write to either counter half suppresses that counter's increment.
        if (wr_en && csr_sel == AddrMcycle) begin
            mcycle_d = {mcycle_q[63:32], csr_wd};
        end else if (wr_en && csr_sel == AddrMcycleh) begin
            mcycle_d = {csr_wd, mcycle_q[31:0]};
        end else begin
            mcycle_d = mcycle_q + 64'd1;
        end

        if (wr_en && csr_sel == AddrMinstret) begin
            minstret_d = {minstret_q[63:32], csr_wd};
        end else if (wr_en && csr_sel == AddrMinstreth) begin
            minstret_d = {csr_wd, minstret_q[31:0]};
        end else begin
            minstret_d = minstret_q + {63'h0, instret_inc};
        end

        if (wr_en && csr_sel == AddrMtvec) begin
            mtvec_d = {csr_wd[31:2], 1'b0, csr_wd[0]};
        end
        if (wr_en && csr_sel == AddrMscratch) begin
            mscratch_d = csr_wd;
        end

        // Trap beats MRET beats software writes on the state they share.
        if (trap_en) begin
            mepc_d   = {trap_pc[31:2], 2'b00};
            mcause_d = trap_cause;
            mtval_d  = trap_tval;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else begin
            if (mret_en) begin
                mie_d  = mpie_q;
                mpie_d = 1'b1;
            end else if (wr_en && csr_sel == AddrMstatus) begin
                mie_d  = csr_wd[3];
                mpie_d = csr_wd[7];
            end

            if (wr_en && csr_sel == AddrMepc) begin
                mepc_d = {csr_wd[31:2], 2'b00};
            end
            if (wr_en && csr_sel == AddrMcause) begin
                mcause_d = csr_wd;
            end
            if (wr_en && csr_sel == AddrMtval) begin
                mtval_d = csr_wd;
            end
        end
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= 32'h0;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mtval_q    <= 32'h0;
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;
    assign mie_out   = mie_q;

endmodule

// File: tb/tb_core_csr_file.sv
// Self-checking bench for core_csr_file: directed vector table, trap/MRET sequences,
// and a randomized run compared against a behavioural CSR model.
module tb_core_csr_file;

    logic        clk;
    logic        rst;
    logic [11:0] csr_sel;
    logic [31:0] csr_wd;
    logic        csr_we;
    logic [31:0] csr_data_out;
    logic        csr_illegal;
    logic        instret_inc;
    logic        trap_en;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_en;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_out;

    int checks   = 0;
    int failures = 0;

    core_csr_file dut (
        .clk          (clk),
        .rst          (rst),
        .csr_sel      (csr_sel),
        .csr_wd       (csr_wd),
        .csr_we       (csr_we),
        .csr_data_out (csr_data_out),
        .csr_illegal  (csr_illegal),
        .instret_inc  (instret_inc),
        .trap_en      (trap_en),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .trap_tval    (trap_tval),
        .mret_en      (mret_en),
        .mtvec_out    (mtvec_out),
        .mepc_out     (mepc_out),
        .mie_out      (mie_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the architectural CSR state.
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cycle, m_instret;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_read(input logic [11:0] a, input logic we,
                                       output logic [31:0] d, output logic ill);
        bit          impl = 1'b1;
        logic [31:0] v    = 32'h0;
        case (a)
            12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: v = 32'h4000_1100;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'hB00, 12'hC00: v = m_cycle[31:0];
            12'hB80, 12'hC80: v = m_cycle[63:32];
            12'hB02, 12'hC02: v = m_instret[31:0];
            12'hB82, 12'hC82: v = m_instret[63:32];
            12'hF14: v = 32'h0;
            default: impl = 1'b0;
        endcase
        ill = !impl || (we && a[11:10] == 2'b11);
        d   = ill ? 32'h0 : v;
    endfunction

    task automatic model_update();
        logic [31:0] d;
        logic        ill;
        bit          w;
        if (rst) begin
            m_mie = 0; m_mpie = 0;
            m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_cycle = 0; m_instret = 0;
        end else begin
            model_read(csr_sel, csr_we, d, ill);
            w = csr_we && !ill;
            if (w && csr_sel == 12'hB00)      m_cycle = {m_cycle[63:32], csr_wd};
            else if (w && csr_sel == 12'hB80) m_cycle = {csr_wd, m_cycle[31:0]};
            else                              m_cycle = m_cycle + 1;
            if (w && csr_sel == 12'hB02)      m_instret = {m_instret[63:32], csr_wd};
            else if (w && csr_sel == 12'hB82) m_instret = {csr_wd, m_instret[31:0]};
            else if (instret_inc)             m_instret = m_instret + 1;
            if (w && csr_sel == 12'h305) m_mtvec = csr_wd & ~32'h2;
            if (w && csr_sel == 12'h340) m_mscratch = csr_wd;
            if (trap_en) begin
                m_mepc   = trap_pc & ~32'h3;
                m_mcause = trap_cause;
                m_mtval  = trap_tval;
                m_mpie   = m_mie;
                m_mie    = 0;
            end else begin
                if (mret_en) begin
                    m_mie  = m_mpie;
                    m_mpie = 1;
                end else if (w && csr_sel == 12'h300) begin
                    m_mie  = csr_wd[3];
                    m_mpie = csr_wd[7];
                end
                if (w && csr_sel == 12'h341) m_mepc = csr_wd & ~32'h3;
                if (w && csr_sel == 12'h342) m_mcause = csr_wd;
                if (w && csr_sel == 12'h343) m_mtval = csr_wd;
            end
        end
    endtask

    task automatic model_check();
        logic [31:0] d;
        logic        ill;
        model_read(csr_sel, csr_we, d, ill);
        check("model_data", csr_data_out, d);
        check("model_illegal", {31'h0, csr_illegal}, {31'h0, ill});
        check("model_mtvec_out", mtvec_out, m_mtvec);
        check("model_mepc_out", mepc_out, m_mepc);
        check("model_mie_out", {31'h0, mie_out}, {31'h0, m_mie});
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 0; csr_sel = 12'h000; csr_wd = 0; csr_we = 0; instret_inc = 0;
        trap_en = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0; mret_en = 0;
    endtask

    task automatic access(input logic [11:0] sel, input logic [31:0] wd, input logic we);
        csr_sel = sel; csr_wd = wd; csr_we = we;
    endtask

    typedef struct {
        logic [11:0] sel;
        logic [31:0] wd;
        logic        we;
        logic [31:0] exp_data;
        logic        exp_ill;
    } vec_t;

    vec_t tbl[22];

    logic [11:0] addrs[17];

    initial begin
        // Row N is applied N cycles after reset falls, so mcycle reads track N until disturbed.
        tbl[0]  = '{12'hB00, 32'h0,         1'b0, 32'h0,         1'b0};
        tbl[1]  = '{12'h300, 32'h0,         1'b0, 32'h0000_1800, 1'b0};
        tbl[2]  = '{12'h305, 32'h0,         1'b0, 32'h0,         1'b0};
        tbl[3]  = '{12'hB00, 32'h0,         1'b0, 32'd3,         1'b0};
        tbl[4]  = '{12'h305, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0};
        tbl[5]  = '{12'h305, 32'h0,         1'b0, 32'hFFFF_FFFD, 1'b0};
        tbl[6]  = '{12'h341, 32'h8000_0003, 1'b1, 32'h0,         1'b0};
        tbl[7]  = '{12'h341, 32'h0,         1'b0, 32'h8000_0000, 1'b0};
        tbl[8]  = '{12'hC00, 32'h1234_5678, 1'b1, 32'h0,         1'b1};
        tbl[9]  = '{12'hF14, 32'h1234_5678, 1'b1, 32'h0,         1'b1};
        tbl[10] = '{12'h7C0, 32'h0,         1'b0, 32'h0,         1'b1};
        tbl[11] = '{12'hC00, 32'h0,         1'b0, 32'd11,        1'b0};
        tbl[12] = '{12'hB80, 32'h0,         1'b1, 32'h0,         1'b0};
        tbl[13] = '{12'hB00, 32'hFFFF_FFFF, 1'b1, 32'd12,        1'b0};
        tbl[14] = '{12'hB00, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b0};
        tbl[15] = '{12'hC00, 32'h0,         1'b0, 32'h0,         1'b0};
        tbl[16] = '{12'hC80, 32'h0,         1'b0, 32'h1,         1'b0};
        tbl[17] = '{12'hB00, 32'd5,         1'b1, 32'd2,         1'b0};
        tbl[18] = '{12'hB00, 32'h0,         1'b0, 32'd5,         1'b0};
        tbl[19] = '{12'h301, 32'hFFFF_FFFF, 1'b1, 32'h4000_1100, 1'b0};
        tbl[20] = '{12'h301, 32'h0,         1'b0, 32'h4000_1100, 1'b0};
        tbl[21] = '{12'hF14, 32'h0,         1'b0, 32'h0,         1'b0};

        addrs = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                  12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                  12'hC82, 12'hF14, 12'h7C0};

        idle();
        rst = 1;
        advance();
        advance();
        rst = 0;

        for (int i = 0; i < 22; i++) begin
            access(tbl[i].sel, tbl[i].wd, tbl[i].we);
            sample();
            check($sformatf("vec%0d_data", i), csr_data_out, tbl[i].exp_data);
            check($sformatf("vec%0d_illegal", i), {31'h0, csr_illegal}, {31'h0, tbl[i].exp_ill});
            advance();
        end

        // Enable MIE, take a trap, then return with MRET.
        idle(); access(12'h300, 32'h8, 1'b1);
        sample(); advance();
        idle(); access(12'h300, 32'h0, 1'b0);
        sample();
        check("mie_set_out", {31'h0, mie_out}, 32'h1);
        check("mie_set_read", csr_data_out, 32'h0000_1808);
        advance();

        idle(); trap_en = 1; trap_pc = 32'h0000_1006; trap_cause = 32'h8000_0007;
        trap_tval = 32'hDEAD_BEEF; access(12'h342, 32'h0, 1'b0);
        sample(); advance();
        idle(); access(12'h342, 32'h0, 1'b0);
        sample();
        check("trap_mcause", csr_data_out, 32'h8000_0007);
        check("trap_mepc_out", mepc_out, 32'h0000_1004);
        check("trap_mie_out", {31'h0, mie_out}, 32'h0);
        advance();
        idle(); access(12'h300, 32'h0, 1'b0);
        sample();
        check("trap_mstatus", csr_data_out, 32'h0000_1880);
        advance();

        idle(); mret_en = 1; access(12'h300, 32'h0, 1'b0);
        sample(); advance();
        idle(); access(12'h300, 32'h0, 1'b0);
        sample();
        check("mret_mstatus", csr_data_out, 32'h0000_1888);
        check("mret_mie_out", {31'h0, mie_out}, 32'h1);
        advance();

        // Trap concurrent with a write to an unrelated CSR, then to mepc.
        idle(); trap_en = 1; trap_pc = 32'h0000_3000; access(12'h340, 32'h0000_A5A5, 1'b1);
        sample(); advance();
        idle(); access(12'h340, 32'h0, 1'b0);
        sample();
        check("trap_mscratch_kept", csr_data_out, 32'h0000_A5A5);
        check("trap_mscratch_mepc", mepc_out, 32'h0000_3000);
        advance();

        idle(); trap_en = 1; trap_pc = 32'h0000_2000; access(12'h341, 32'h0000_0040, 1'b1);
        sample(); advance();
        idle(); access(12'h341, 32'h0, 1'b0);
        sample();
        check("trap_mepc_write_lost", csr_data_out, 32'h0000_2000);
        check("trap_mepc_out_lost", mepc_out, 32'h0000_2000);
        advance();

        // Reset beats a concurrent trap and write.
        idle(); rst = 1; trap_en = 1; trap_pc = 32'h0000_4444; access(12'h340, 32'h1, 1'b1);
        sample(); advance();
        idle(); access(12'h340, 32'h0, 1'b0);
        sample();
        check("rst_mscratch", csr_data_out, 32'h0);
        check("rst_mepc_out", mepc_out, 32'h0);
        advance();

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            logic [31:0] r;
            int          k;
            r = $urandom;
            k = $urandom_range(0, 19);
            rst         = ($urandom_range(0, 63) == 0);
            csr_sel     = (k < 17) ? addrs[k] : r[11:0];
            csr_wd      = $urandom;
            csr_we      = ($urandom_range(0, 2) == 0);
            instret_inc = 1'($urandom_range(0, 1));
            trap_en     = ($urandom_range(0, 9) == 0);
            mret_en     = ($urandom_range(0, 9) == 0);
            trap_cause  = $urandom;
            trap_pc     = $urandom;
            trap_tval   = $urandom;
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
